cell_sched: RTL and testbench

CELL_SCHED -- requirements
Module: cell_sched

---
 rtl/cell_sched.sv | 204 ++++++++++++++++++++
 tb/tb_cell_sched.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_sched.sv
// cell_sched: iteration scheduler for a ROWS x COLS grid of cells that share one
// cell datapath. Each iteration issues every cell once (row-major), writes the
// returned results into the bank opposite the one being read, then swaps banks.
// Optional build macro CNN_CONV_STOP_EN: end the run early, with conv=1, when an
// iteration leaves every cell unchanged.
module cell_sched #(
  parameter int WIDTH   = 16,
  parameter int ROWS    = 8,
  parameter int COLS    = 8,
  parameter int MAX_OUT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [15:0]              max_iter,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              iter_count,
  output logic                     conv,
  output logic                     issue_valid,
  input  logic                     issue_ready,
  output logic [$clog2(ROWS)-1:0]  issue_row,
  output logic [$clog2(COLS)-1:0]  issue_col,
  output logic                     rd_bank,
  input  logic                     res_valid,
  input  logic [WIDTH-1:0]         res_data,
  input  logic [WIDTH-1:0]         res_prev,
  output logic                     wr_en,
  output logic [$clog2(ROWS)-1:0]  wr_row,
  output logic [$clog2(COLS)-1:0]  wr_col,
  output logic [WIDTH-1:0]         wr_data,
  output logic                     wr_bank,
  output logic [2:0]               state_dbg
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  localparam logic [OW-1:0] OUT_LIM  = OW'(MAX_OUT);

  // Handshake: a cell transfers on any cycle with issue_valid && issue_ready;
  // while issue_valid is high and issue_ready low, issue_row/issue_col hold.
  // res_valid has no back-pressure: results return in issue order and are
  // accepted whenever at least one operation is outstanding.

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    DRAIN = 3'd2,
    SWAP  = 3'd3,
    FIN   = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [15:0]     max_q;
  logic [OW-1:0]   outstanding;
  logic            start_acc, xfer, res_acc, last_cell, stop_now, conv_hit;

  assign start_acc   = (state == IDLE) && start;
  assign issue_valid = (state == ISSUE) && (outstanding < OUT_LIM);
  assign xfer        = issue_valid && issue_ready;
  assign res_acc     = res_valid && (outstanding != '0);
  assign last_cell   = (issue_row == LAST_ROW) && (issue_col == LAST_COL);
  assign stop_now    = ((iter_count + 16'd1) == max_q) || conv_hit;
  assign busy        = (state != IDLE);
  assign done        = (state == FIN);
  assign state_dbg   = state;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; DRAIN waits for the last write to leave the pipeline.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (max_iter == 16'd0) ? FIN : ISSUE;
      ISSUE:   if (xfer && last_cell) state_nxt = DRAIN;
      DRAIN:   if ((outstanding == '0) && !wr_en) state_nxt = SWAP;
      SWAP:    state_nxt = stop_now ? FIN : ISSUE;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Issue pointer: row-major walk, rewound at start and at every bank swap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_row <= '0;
      issue_col <= '0;
    end else if (start_acc || (state == SWAP)) begin
      issue_row <= '0;
      issue_col <= '0;
    end else if (xfer) begin
      if (issue_col == LAST_COL) begin
        issue_col <= '0;
        issue_row <= (issue_row == LAST_ROW) ? '0 : issue_row + 1'b1;
      end else begin
        issue_col <= issue_col + 1'b1;
      end
    end
  end

  // Outstanding operations: a transfer and a result in one cycle cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else begin
      case ({xfer, res_acc})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Write stage: an accepted result is written one cycle later into the other bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_data <= '0;
      wr_bank <= 1'b0;
    end else begin
      wr_en <= res_acc;
      if (res_acc) begin
        wr_data <= res_data;
        wr_bank <= ~rd_bank;
      end
    end
  end

  // Write pointer: results come back in issue order, so it walks row-major too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_row <= '0;
      wr_col <= '0;
    end else if (start_acc) begin
      wr_row <= '0;
      wr_col <= '0;
    end else if (wr_en) begin
      if (wr_col == LAST_COL) begin
        wr_col <= '0;
        wr_row <= (wr_row == LAST_ROW) ? '0 : wr_row + 1'b1;
      end else begin
        wr_col <= wr_col + 1'b1;
      end
    end
  end

  // Run bookkeeping: limit captured at start, count and bank advanced at SWAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q      <= '0;
      iter_count <= '0;
      rd_bank    <= 1'b0;
    end else if (start_acc) begin
      max_q      <= max_iter;
      iter_count <= '0;
    end else if (state == SWAP) begin
      iter_count <= iter_count + 16'd1;
      rd_bank    <= ~rd_bank;
    end
  end

`ifdef CNN_CONV_STOP_EN
  localparam int CHW = $clog2(ROWS * COLS + 1);
  logic [CHW-1:0]   chg_cnt;
  logic [WIDTH-1:0] prev_q;
  logic             conv_q;

  assign conv_hit = (chg_cnt == '0);
  assign conv     = conv_q;

  // Previous value of the cell travels alongside its result into the write stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       prev_q <= '0;
    else if (res_acc) prev_q <= res_prev;
  end

  // Count cells whose written value differs from their previous value this iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               chg_cnt <= '0;
    else if (start_acc || (state == SWAP))    chg_cnt <= '0;
    else if (wr_en && (wr_data != prev_q))    chg_cnt <= chg_cnt + 1'b1;
  end

  // Convergence flag: cleared at start, set when a swap sees an unchanged grid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                conv_q <= 1'b0;
    else if (start_acc)        conv_q <= 1'b0;
    else if (state == SWAP)    conv_q <= conv_hit;
  end
`else
  logic unused_prev;
  assign unused_prev = ^res_prev;
  assign conv_hit    = 1'b0;
  assign conv        = 1'b0;
`endif

endmodule

// File: tb/tb_cell_sched.sv
// tb_cell_sched: directed bench for cell_sched on a 2x4 grid with MAX_OUT=4.
// A small datapath model returns results in issue order with 2-cycle latency
// (or holds them back on request); a scoreboard predicts every state write.
`timescale 1ns/1ps
module tb_cell_sched;
  localparam int WIDTH   = 16;
  localparam int ROWS    = 2;
  localparam int COLS    = 4;
  localparam int MAX_OUT = 4;
  localparam int NC      = ROWS * COLS;
  localparam int RW      = $clog2(ROWS);
  localparam int CW      = $clog2(COLS);
  localparam int W       = RW + CW + WIDTH;

  logic             clk, rst_n, start;
  logic [15:0]      max_iter;
  logic             busy, done, conv, issue_valid, issue_ready, rd_bank;
  logic [15:0]      iter_count;
  logic [RW-1:0]    issue_row, wr_row;
  logic [CW-1:0]    issue_col, wr_col;
  logic             res_valid, wr_en, wr_bank;
  logic [WIDTH-1:0] res_data, res_prev, wr_data;
  logic [2:0]       state_dbg;

  cell_sched #(.WIDTH(WIDTH), .ROWS(ROWS), .COLS(COLS), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .max_iter(max_iter),
    .busy(busy), .done(done), .iter_count(iter_count), .conv(conv),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_row(issue_row), .issue_col(issue_col), .rd_bank(rd_bank),
    .res_valid(res_valid), .res_data(res_data), .res_prev(res_prev),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .wr_bank(wr_bank), .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- datapath model ----------------
  typedef struct {
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] prev;
    int               due;
  } pend_t;
  pend_t pend[$];

  int   cyc = 0;
  logic hold = 1'b0;       // results only leave when released
  int   rel_total = 0;     // releases granted while holding
  int   rel_done = 0;      // releases used while holding
  logic rand_rdy = 1'b0;
  logic rdy_val = 1'b1;
  logic drop_pend = 1'b0;
  logic same_all = 1'b0;   // res_prev equals res_data in every iteration
  logic same_from2 = 1'b0; // res_prev equals res_data from iteration 2 on

  initial begin
    issue_ready = 1'b1;
    res_valid   = 1'b0;
    res_data    = '0;
    res_prev    = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (drop_pend) pend.delete();
      issue_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_val;
      if (pend.size() > 0 && pend[0].due <= cyc && (!hold || rel_done < rel_total)) begin
        res_valid = 1'b1;
        res_data  = pend[0].data;
        res_prev  = pend[0].prev;
        void'(pend.pop_front());
        if (hold) rel_done++;
      end else begin
        res_valid = 1'b0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int   xfers = 0, writes = 0, rets = 0, toggles = 0;
  int   cell_idx = 0, it_idx = 0, wcnt = 0;
  logic exp_rdb = 1'b0, rdb_prev = 1'b0, stalled = 1'b0;
  logic [RW-1:0] held_row;
  logic [CW-1:0] held_col;

  initial begin
    logic [WIDTH-1:0] d, p;
    logic [W-1:0]     e;
    logic             eb;
    forever begin
      @(negedge clk);
      if (rd_bank !== rdb_prev) toggles++;
      rdb_prev = rd_bank;
      if (!rst_n) begin
        exp_q.delete();
        cell_idx = 0; it_idx = 0; wcnt = 0; exp_rdb = 1'b0; stalled = 1'b0;
      end else begin
        if (start && !busy) begin
          cell_idx = 0;
          it_idx   = 0;
        end
        if (stalled && issue_valid) begin
          chk("stall_row", 32'(issue_row), 32'(held_row));
          chk("stall_col", 32'(issue_col), 32'(held_col));
        end
        stalled  = issue_valid && !issue_ready;
        held_row = issue_row;
        held_col = issue_col;
        if (issue_valid && issue_ready) begin
          chk("order_row", 32'(issue_row), 32'(cell_idx / COLS));
          chk("order_col", 32'(issue_col), 32'(cell_idx % COLS));
          d = WIDTH'(xfers * 37 + 165);
          p = (same_all || (same_from2 && it_idx >= 1)) ? d : ~d;
          pend.push_back('{data: d, prev: p, due: cyc + 2});
          exp_q.push_back({RW'(cell_idx / COLS), CW'(cell_idx % COLS), d});
          xfers++;
          cell_idx++;
          if (cell_idx == NC) begin
            cell_idx = 0;
            it_idx++;
          end
        end
        if (res_valid) rets++;
        if (wr_en) begin
          writes++;
          chk("wr_has_exp", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            eb = ~exp_rdb;
            chk("wr_row", 32'(wr_row), 32'(e[W-1 -: RW]));
            chk("wr_col", 32'(wr_col), 32'(e[WIDTH +: CW]));
            chk("wr_data", 32'(wr_data), 32'(e[WIDTH-1:0]));
            chk("wr_bank", 32'(wr_bank), 32'(eb));
            wcnt++;
            if (wcnt == NC) begin
              wcnt    = 0;
              exp_rdb = ~exp_rdb;
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input logic [15:0] mi);
    @(posedge clk); #1;
    max_iter = mi;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  int x0, w0, t0, r0;

  initial begin
    rst_n = 1'b0; start = 1'b0; max_iter = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_issue_valid", 32'(issue_valid), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_conv", 32'(conv), 0);
    chk("rst_rd_bank", 32'(rd_bank), 0);
    chk("rst_iter", 32'(iter_count), 0);
    chk("rst_state", 32'(state_dbg), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Three full iterations, ready always high; a second start mid-run and a
    // changed max_iter must not disturb the run.
    x0 = xfers; w0 = writes; t0 = toggles;
    pulse_start(16'd3);
    chk("a_busy_after_start", 32'(busy), 1);
    max_iter = 16'd1;
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(400);
    chk("a_iter_at_done", 32'(iter_count), 3);
    chk("a_busy_in_fin", 32'(busy), 1);
    chk("a_conv", 32'(conv), 0);
    chk("a_xfers", 32'(xfers - x0), 3 * NC);
    chk("a_writes", 32'(writes - w0), 3 * NC);
    chk("a_toggles", 32'(toggles - t0), 3);
    @(negedge clk);
    chk("a_done_pulse", 32'(done), 0);
    chk("a_busy_after", 32'(busy), 0);
    chk("a_iter_hold", 32'(iter_count), 3);
    chk("a_rd_bank", 32'(rd_bank), 1);

    // max_iter = 0: straight to FIN, done in the cycle right after the start edge.
    x0 = xfers;
    pulse_start(16'd0);
    @(negedge clk);
    chk("b_done", 32'(done), 1);
    chk("b_issue_valid", 32'(issue_valid), 0);
    chk("b_iter", 32'(iter_count), 0);
    @(negedge clk);
    chk("b_done_drop", 32'(done), 0);
    chk("b_busy", 32'(busy), 0);
    chk("b_xfers", 32'(xfers - x0), 0);
    chk("b_rd_bank", 32'(rd_bank), 1);

    // Results withheld: four in flight, then one return re-opens issue, and a
    // return coinciding with a transfer leaves the in-flight count at three.
    x0 = xfers; w0 = writes;
    hold = 1'b1; rel_total = rel_done;
    pulse_start(16'd1);
    repeat (10) @(negedge clk);
    chk("c_xfers_cap", 32'(xfers - x0), MAX_OUT);
    chk("c_valid_low", 32'(issue_valid), 0);
    chk("c_state_issue", 32'(state_dbg), 1);
    rel_total = rel_done + 1;
    @(negedge clk);
    chk("c_valid_low_during_res", 32'(issue_valid), 0);
    rel_total = rel_total + 1;
    @(negedge clk);
    chk("c_valid_reassert", 32'(issue_valid), 1);
    chk("c_res_with_xfer", 32'(res_valid), 1);
    @(negedge clk);
    chk("c_valid_after_both", 32'(issue_valid), 1);
    @(negedge clk);
    chk("c_valid_full_again", 32'(issue_valid), 0);
    chk("c_xfers_6", 32'(xfers - x0), 6);
    hold = 1'b0;
    wait_done(400);
    chk("c_writes", 32'(writes - w0), NC);
    chk("c_iter", 32'(iter_count), 1);

    // Random back-pressure on issue_ready over two iterations.
    x0 = xfers; w0 = writes;
    rand_rdy = 1'b1;
    pulse_start(16'd2);
    wait_done(800);
    rand_rdy = 1'b0;
    chk("d_xfers", 32'(xfers - x0), 2 * NC);
    chk("d_writes", 32'(writes - w0), 2 * NC);
    chk("d_iter", 32'(iter_count), 2);

`ifdef CNN_CONV_STOP_EN
    // Iteration 2 changes nothing: the run stops there with conv set.
    w0 = writes;
    same_from2 = 1'b1;
    pulse_start(16'd10);
    wait_done(800);
    same_from2 = 1'b0;
    chk("e_iter", 32'(iter_count), 2);
    chk("e_conv", 32'(conv), 1);
    chk("e_writes", 32'(writes - w0), 2 * NC);
`else
    // Without early stop, unchanged cells still run every iteration.
    w0 = writes;
    same_all = 1'b1;
    pulse_start(16'd3);
    wait_done(800);
    same_all = 1'b0;
    chk("e_iter", 32'(iter_count), 3);
    chk("e_conv", 32'(conv), 0);
    chk("e_writes", 32'(writes - w0), 3 * NC);
`endif
    repeat (2) @(negedge clk);

    // Reset in DRAIN with three results outstanding.
    x0 = xfers; w0 = writes; r0 = rets;
    hold = 1'b1; rel_total = rel_done + 5;
    pulse_start(16'd5);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if ((xfers - x0) == NC && (rets - r0) == 5 && !wr_en) break;
    end
    chk("f_state_drain", 32'(state_dbg), 2);
    chk("f_writes_before", 32'(writes - w0), 5);
    chk("f_xfers_before", 32'(xfers - x0), NC);
    #2 rst_n = 1'b0;
    #1;
    chk("f_busy_async", 32'(busy), 0);
    chk("f_issue_valid_async", 32'(issue_valid), 0);
    chk("f_wr_en_async", 32'(wr_en), 0);
    chk("f_state_async", 32'(state_dbg), 0);
    chk("f_iter_async", 32'(iter_count), 0);
    chk("f_rd_bank_async", 32'(rd_bank), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    w0 = writes;
    rel_total = rel_done + 3;
    repeat (8) @(negedge clk);
    chk("f_late_no_write", 32'(writes - w0), 0);
    hold = 1'b0;
    drop_pend = 1'b1;
    @(negedge clk);
    drop_pend = 1'b0;

    // A fresh run after the reset behaves normally.
    w0 = writes;
    pulse_start(16'd1);
    wait_done(400);
    chk("g_iter", 32'(iter_count), 1);
    chk("g_writes", 32'(writes - w0), NC);
    @(negedge clk);
    chk("g_rd_bank", 32'(rd_bank), 1);
    chk("g_busy", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
